// File: rtl/mux_arb_n.sv
// mux_arb_n -- N-channel, WIDTH-bit multiplexer with a registered output stage.
//
// Several producers share one consumer. Each input channel and the output use a
// valid/ready handshake: a word moves across an interface on a clock edge where
// both valid and ready are high. Valid must not depend on ready; ready may
// depend on valid. At most one in_ready bit is high in any cycle.
//
// Selection:
//   MODE=0 : channel chosen by sel; a sel value >= CHANNELS grants nothing.
//   MODE=1 : round-robin, first valid channel searching from rr_ptr upward
//            (wrapping); rr_ptr moves to granted+1 after each input transfer.
//
// Optional build macro MUX_SKID_EN:
//   undefined : single output register, FSM EMPTY/FULL, in_ready depends
//               combinationally on out_ready.
//   defined   : output register plus a skid register, FSM EMPTY/ONE/TWO,
//               in_ready derived from registered state only.
//
// Ports:
//   clk, reset   rising-edge clock, synchronous active-high reset
//   in_data      CHANNELS*WIDTH flattened words, channel i at [i*WIDTH +: WIDTH]
//   in_valid     per-channel valid
//   in_ready     per-channel ready (the only unregistered output)
//   sel          channel select (MODE=0 only)
//   out_data     registered selected word
//   out_chan     index of the channel that supplied out_data
//   out_valid    output holds a word
//   out_ready    consumer accepts the word
//   dbg_state    output-stage FSM state (observation only)
//   dbg_rr_ptr   round-robin pointer (observation only)
module mux_arb_n #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4,
    parameter int MODE     = 0,
    localparam int SEL_W   = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic [SEL_W-1:0]          sel,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [1:0]                dbg_state,
    output logic [SEL_W-1:0]          dbg_rr_ptr
);

    // In the single-stage build ST_ONE is the FULL state.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
`ifdef MUX_SKID_EN
    localparam logic [1:0] ST_TWO   = 2'd2;
`endif

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0] out_chan_q, out_chan_d;
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
`ifdef MUX_SKID_EN
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic [SEL_W-1:0] skid_chan_q, skid_chan_d;
`endif

    logic             grant_vld;
    logic [SEL_W-1:0] grant_idx;
    logic             can_accept;
    logic             accept;
    logic             drain;
    logic [WIDTH-1:0] acc_data;

    assign out_valid = (state_q != ST_EMPTY);
    assign drain     = out_valid && out_ready;

`ifdef MUX_SKID_EN
    // Room exists as long as the skid entry is free; out_ready is not involved.
    assign can_accept = (state_q != ST_TWO);
`else
    assign can_accept = !out_valid || out_ready;
`endif

    // Grant selection.
    always_comb begin
        int idx;
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = 0;
        if (MODE == 0) begin
            if (int'(sel) < CHANNELS) begin
                grant_vld = 1'b1;
                grant_idx = sel;
            end
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                idx = (int'(rr_ptr_q) + k) % CHANNELS;
                if (!grant_vld && in_valid[idx]) begin
                    grant_vld = 1'b1;
                    grant_idx = idx[SEL_W-1:0];
                end
            end
        end
    end

    // In MODE=1 a grant only exists for a valid channel, so in_ready follows
    // in_valid there; in MODE=0 ready is offered whether or not data is present.
    always_comb begin
        in_ready = '0;
        if (!reset && can_accept && grant_vld) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    assign accept   = |(in_valid & in_ready);
    assign acc_data = in_data[int'(grant_idx)*WIDTH +: WIDTH];

    // Next-state logic for the output stage and the round-robin pointer.
    always_comb begin
        int nxt;
        state_d    = state_q;
        out_data_d = out_data_q;
        out_chan_d = out_chan_q;
        rr_ptr_d   = rr_ptr_q;
        nxt        = 0;
        if (accept) begin
            nxt = int'(grant_idx) + 1;
            if (nxt >= CHANNELS) begin
                nxt = 0;
            end
            rr_ptr_d = nxt[SEL_W-1:0];
        end
`ifdef MUX_SKID_EN
        skid_data_d = skid_data_q;
        skid_chan_d = skid_chan_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    out_data_d = acc_data;
                    out_chan_d = grant_idx;
                    state_d    = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && !drain) begin
                    // Output stalled: park the new word behind the held one.
                    skid_data_d = acc_data;
                    skid_chan_d = grant_idx;
                    state_d     = ST_TWO;
                end else if (accept) begin
                    out_data_d = acc_data;
                    out_chan_d = grant_idx;
                end else if (drain) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (drain) begin
                    out_data_d = skid_data_q;
                    out_chan_d = skid_chan_q;
                    state_d    = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
`else
        if (accept) begin
            // Covers both fill-from-empty and simultaneous drain-and-fill.
            out_data_d = acc_data;
            out_chan_d = grant_idx;
            state_d    = ST_ONE;
        end else if (drain) begin
            state_d = ST_EMPTY;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            rr_ptr_q    <= '0;
`ifdef MUX_SKID_EN
            skid_data_q <= '0;
            skid_chan_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            rr_ptr_q    <= rr_ptr_d;
`ifdef MUX_SKID_EN
            skid_data_q <= skid_data_d;
            skid_chan_q <= skid_chan_d;
`endif
        end
    end

    assign out_data   = out_data_q;
    assign out_chan   = out_chan_q;
    assign dbg_state  = state_q;
    assign dbg_rr_ptr = rr_ptr_q;

endmodule

// File: tb/tb_mux_arb_n.sv
// Bench for mux_arb_n: a MODE=0 and a MODE=1 instance (4 x 32-bit) plus a
// MODE=0 3 x 8-bit instance so that an out-of-range sel can be driven.
// Inputs change on the falling edge; registered outputs are observed on the
// falling edge after the rising edge that loaded them.
module tb_mux_arb_n;
    localparam int W = 32;
    localparam int N = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [N*W-1:0] in_data0, in_data1;
    logic [N-1:0]   in_valid0, in_valid1, in_ready0, in_ready1;
    logic [1:0]     sel0, sel1, out_chan0, out_chan1;
    logic [W-1:0]   out_data0, out_data1;
    logic           out_valid0, out_valid1, out_ready0, out_ready1;
    logic [1:0]     dbg_state0, dbg_state1, dbg_rr0, dbg_rr1;

    logic [23:0]    in_data2;
    logic [2:0]     in_valid2, in_ready2;
    logic [1:0]     sel2, out_chan2, dbg_state2, dbg_rr2;
    logic [7:0]     out_data2;
    logic           out_valid2, out_ready2;

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q[$];

    mux_arb_n #(.WIDTH(W), .CHANNELS(N), .MODE(0)) u_dut0 (
        .clk(clk), .reset(reset), .in_data(in_data0), .in_valid(in_valid0),
        .in_ready(in_ready0), .sel(sel0), .out_data(out_data0), .out_chan(out_chan0),
        .out_valid(out_valid0), .out_ready(out_ready0), .dbg_state(dbg_state0),
        .dbg_rr_ptr(dbg_rr0));

    mux_arb_n #(.WIDTH(W), .CHANNELS(N), .MODE(1)) u_dut1 (
        .clk(clk), .reset(reset), .in_data(in_data1), .in_valid(in_valid1),
        .in_ready(in_ready1), .sel(sel1), .out_data(out_data1), .out_chan(out_chan1),
        .out_valid(out_valid1), .out_ready(out_ready1), .dbg_state(dbg_state1),
        .dbg_rr_ptr(dbg_rr1));

    mux_arb_n #(.WIDTH(8), .CHANNELS(3), .MODE(0)) u_dut2 (
        .clk(clk), .reset(reset), .in_data(in_data2), .in_valid(in_valid2),
        .in_ready(in_ready2), .sel(sel2), .out_data(out_data2), .out_chan(out_chan2),
        .out_valid(out_valid2), .out_ready(out_ready2), .dbg_state(dbg_state2),
        .dbg_rr_ptr(dbg_rr2));

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic test_reset();
        reset = 1'b1;
        in_data0 = '0; in_data1 = '0; in_data2 = '0;
        in_valid0 = 4'b1111; in_valid1 = 4'b1111; in_valid2 = 3'b111;
        sel0 = 2'd2; sel1 = 2'd0; sel2 = 2'd0;
        out_ready0 = 1'b1; out_ready1 = 1'b1; out_ready2 = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (in_ready0 !== 4'b0000) begin n_fail++; $display("FAIL rst_in_ready0: got %b want %b", in_ready0, 4'b0000); end
        n_checks++; if (in_ready1 !== 4'b0000) begin n_fail++; $display("FAIL rst_in_ready1: got %b want %b", in_ready1, 4'b0000); end
        n_checks++; if (out_valid0 !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid0: got %b want 0", out_valid0); end
        n_checks++; if (out_data0 !== 32'h0) begin n_fail++; $display("FAIL rst_out_data0: got %h want 0", out_data0); end
        n_checks++; if (out_chan0 !== 2'd0) begin n_fail++; $display("FAIL rst_out_chan0: got %0d want 0", out_chan0); end
        n_checks++; if (dbg_rr1 !== 2'd0) begin n_fail++; $display("FAIL rst_rr_ptr: got %0d want 0", dbg_rr1); end
        @(negedge clk);
        reset = 1'b0;
        in_valid0 = '0; in_valid1 = '0; in_valid2 = '0;
    endtask

    task automatic test_select();
        @(negedge clk);
        sel0 = 2'd2; in_valid0 = 4'b0100; out_ready0 = 1'b1;
        in_data0 = {32'h33333333, 32'hDEADBEEF, 32'h11111111, 32'h00000000};
        #1;
        n_checks++; if (in_ready0 !== 4'b0100) begin n_fail++; $display("FAIL sel_in_ready: got %b want %b", in_ready0, 4'b0100); end
        @(negedge clk);
        n_checks++; if (out_valid0 !== 1'b1) begin n_fail++; $display("FAIL sel_out_valid: got %b want 1", out_valid0); end
        n_checks++; if (out_data0 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sel_out_data: got %h want deadbeef", out_data0); end
        n_checks++; if (out_chan0 !== 2'd2) begin n_fail++; $display("FAIL sel_out_chan: got %0d want 2", out_chan0); end
        in_valid0 = 4'b0000; sel0 = 2'd1;
        #1;
        // MODE=0 offers ready on the selected channel even with no valid data.
        n_checks++; if (in_ready0 !== 4'b0010) begin n_fail++; $display("FAIL sel_ready_no_valid: got %b want %b", in_ready0, 4'b0010); end
        @(negedge clk);
        n_checks++; if (out_valid0 !== 1'b0) begin n_fail++; $display("FAIL sel_drain: got %b want 0", out_valid0); end
    endtask

    task automatic test_sel_range();
        @(negedge clk);
        in_data2 = {8'hC2, 8'hC1, 8'hC0}; in_valid2 = 3'b111; sel2 = 2'd3; out_ready2 = 1'b1;
        #1;
        n_checks++; if (in_ready2 !== 3'b000) begin n_fail++; $display("FAIL range_in_ready: got %b want %b", in_ready2, 3'b000); end
        @(negedge clk);
        n_checks++; if (out_valid2 !== 1'b0) begin n_fail++; $display("FAIL range_out_valid: got %b want 0", out_valid2); end
        sel2 = 2'd2;
        #1;
        n_checks++; if (in_ready2 !== 3'b100) begin n_fail++; $display("FAIL range_top_ready: got %b want %b", in_ready2, 3'b100); end
        @(negedge clk);
        n_checks++; if (out_data2 !== 8'hC2) begin n_fail++; $display("FAIL range_top_data: got %h want c2", out_data2); end
        n_checks++; if (out_chan2 !== 2'd2) begin n_fail++; $display("FAIL range_top_chan: got %0d want 2", out_chan2); end
        in_valid2 = 3'b000;
        @(negedge clk);
    endtask

`ifndef MUX_SKID_EN
    task automatic test_stall();
        @(negedge clk);
        sel0 = 2'd0; in_valid0 = 4'b0001; out_ready0 = 1'b0;
        in_data0[0 +: W] = 32'h11111111;
        #1;
        n_checks++; if (in_ready0 !== 4'b0001) begin n_fail++; $display("FAIL stall_first_ready: got %b want %b", in_ready0, 4'b0001); end
        @(negedge clk);
        in_data0[0 +: W] = 32'h33333333;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++; if (in_ready0 !== 4'b0000) begin n_fail++; $display("FAIL stall_ready[%0d]: got %b want %b", i, in_ready0, 4'b0000); end
            n_checks++; if (out_data0 !== 32'h11111111) begin n_fail++; $display("FAIL stall_hold[%0d]: got %h want 11111111", i, out_data0); end
            n_checks++; if (out_valid0 !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d]: got %b want 1", i, out_valid0); end
            @(negedge clk);
        end
        sel0 = 2'd1; in_valid0 = 4'b0010; out_ready0 = 1'b1;
        in_data0[W +: W] = 32'h22222222;
        #1;
        n_checks++; if (in_ready0 !== 4'b0010) begin n_fail++; $display("FAIL stall_release_ready: got %b want %b", in_ready0, 4'b0010); end
        @(negedge clk);
        n_checks++; if (out_valid0 !== 1'b1) begin n_fail++; $display("FAIL stall_refill_valid: got %b want 1", out_valid0); end
        n_checks++; if (out_data0 !== 32'h22222222) begin n_fail++; $display("FAIL stall_refill_data: got %h want 22222222", out_data0); end
        n_checks++; if (out_chan0 !== 2'd1) begin n_fail++; $display("FAIL stall_refill_chan: got %0d want 1", out_chan0); end
        in_valid0 = 4'b0000;
        @(negedge clk);
        n_checks++; if (out_valid0 !== 1'b0) begin n_fail++; $display("FAIL stall_empty: got %b want 0", out_valid0); end
    endtask
`else
    task automatic test_skid();
        @(negedge clk);
        sel0 = 2'd0; in_valid0 = 4'b0001; out_ready0 = 1'b0;
        in_data0[0 +: W] = 32'h1;
        #1;
        n_checks++; if (in_ready0 !== 4'b0001) begin n_fail++; $display("FAIL skid_ready_empty: got %b want %b", in_ready0, 4'b0001); end
        @(negedge clk);
        in_data0[0 +: W] = 32'h2;
        #1;
        n_checks++; if (in_ready0 !== 4'b0001) begin n_fail++; $display("FAIL skid_ready_one: got %b want %b", in_ready0, 4'b0001); end
        n_checks++; if (out_data0 !== 32'h1) begin n_fail++; $display("FAIL skid_first_data: got %h want 1", out_data0); end
        @(negedge clk);
        in_data0[0 +: W] = 32'h3;
        #1;
        n_checks++; if (in_ready0 !== 4'b0000) begin n_fail++; $display("FAIL skid_ready_full: got %b want %b", in_ready0, 4'b0000); end
        n_checks++; if (dbg_state0 !== 2'd2) begin n_fail++; $display("FAIL skid_state_two: got %0d want 2", dbg_state0); end
        out_ready0 = 1'b1;
        #1;
        n_checks++; if (in_ready0 !== 4'b0000) begin n_fail++; $display("FAIL skid_ready_comb: got %b want %b", in_ready0, 4'b0000); end
        n_checks++; if (out_data0 !== 32'h1) begin n_fail++; $display("FAIL skid_hold_data: got %h want 1", out_data0); end
        in_valid0 = 4'b0000;
        @(negedge clk);
        n_checks++; if (out_data0 !== 32'h2) begin n_fail++; $display("FAIL skid_second_data: got %h want 2", out_data0); end
        n_checks++; if (out_valid0 !== 1'b1) begin n_fail++; $display("FAIL skid_second_valid: got %b want 1", out_valid0); end
        @(negedge clk);
        n_checks++; if (out_valid0 !== 1'b0) begin n_fail++; $display("FAIL skid_empty: got %b want 0", out_valid0); end
    endtask
`endif

    task automatic test_round_robin();
        logic [W-1:0] exp_d;
        logic [1:0]   exp_c;
        @(negedge clk);
        in_data1 = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        in_valid1 = 4'b1111; out_ready1 = 1'b1;
        for (int k = 0; k < 6; k++) exp_q.push_back(32'hA0 + W'(k % 4));
        #1;
        n_checks++; if (in_ready1 !== 4'b0001) begin n_fail++; $display("FAIL rr_first_ready: got %b want %b", in_ready1, 4'b0001); end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            exp_d = exp_q.pop_front();
            exp_c = k[1:0];
            n_checks++; if (out_valid1 !== 1'b1) begin n_fail++; $display("FAIL rr_valid[%0d]: got %b want 1", k, out_valid1); end
            n_checks++; if (out_data1 !== exp_d) begin n_fail++; $display("FAIL rr_data[%0d]: got %h want %h", k, out_data1, exp_d); end
            n_checks++; if (out_chan1 !== exp_c) begin n_fail++; $display("FAIL rr_chan[%0d]: got %0d want %0d", k, out_chan1, exp_c); end
        end
        in_valid1 = 4'b0000;
        @(negedge clk);
        n_checks++; if (out_valid1 !== 1'b0) begin n_fail++; $display("FAIL rr_drain: got %b want 0", out_valid1); end
        n_checks++; if (dbg_rr1 !== 2'd2) begin n_fail++; $display("FAIL rr_ptr_end: got %0d want 2", dbg_rr1); end
    endtask

    task automatic test_rr_skip();
        logic [1:0]   exp_ch[3]  = '{2'd3, 2'd1, 2'd3};
        logic [1:0]   exp_ptr[3] = '{2'd0, 2'd2, 2'd0};
        logic [W-1:0] exp_dat[3] = '{32'hB3, 32'hB1, 32'hB3};
        logic [3:0]   exp_rdy[3] = '{4'b0010, 4'b1000, 4'b0010};
        in_data1 = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
        in_valid1 = 4'b1010; out_ready1 = 1'b1;
        #1;
        n_checks++; if (in_ready1 !== 4'b1000) begin n_fail++; $display("FAIL skip_first_ready: got %b want %b", in_ready1, 4'b1000); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++; if (out_chan1 !== exp_ch[i]) begin n_fail++; $display("FAIL skip_chan[%0d]: got %0d want %0d", i, out_chan1, exp_ch[i]); end
            n_checks++; if (out_data1 !== exp_dat[i]) begin n_fail++; $display("FAIL skip_data[%0d]: got %h want %h", i, out_data1, exp_dat[i]); end
            n_checks++; if (dbg_rr1 !== exp_ptr[i]) begin n_fail++; $display("FAIL skip_ptr[%0d]: got %0d want %0d", i, dbg_rr1, exp_ptr[i]); end
            #1;
            n_checks++; if (in_ready1 !== exp_rdy[i]) begin n_fail++; $display("FAIL skip_ready[%0d]: got %b want %b", i, in_ready1, exp_rdy[i]); end
        end
        in_valid1 = 4'b0000;
        repeat (3) @(negedge clk);
        n_checks++; if (dbg_rr1 !== 2'd0) begin n_fail++; $display("FAIL skip_ptr_idle: got %0d want 0", dbg_rr1); end
        n_checks++; if (out_valid1 !== 1'b0) begin n_fail++; $display("FAIL skip_idle_valid: got %b want 0", out_valid1); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        in_data1[2*W +: W] = 32'h5A5A5A5A; in_valid1 = 4'b0100; out_ready1 = 1'b0;
        in_data0[3*W +: W] = 32'h5A5A5A5A; in_valid0 = 4'b1000; sel0 = 2'd3; out_ready0 = 1'b0;
        @(negedge clk);
        in_valid1 = 4'b0000; in_valid0 = 4'b0000;
        n_checks++; if (out_data1 !== 32'h5A5A5A5A) begin n_fail++; $display("FAIL mid_fill_data: got %h want 5a5a5a5a", out_data1); end
        n_checks++; if (dbg_rr1 !== 2'd3) begin n_fail++; $display("FAIL mid_fill_ptr: got %0d want 3", dbg_rr1); end
        n_checks++; if (out_valid0 !== 1'b1) begin n_fail++; $display("FAIL mid_fill_valid0: got %b want 1", out_valid0); end
        reset = 1'b1;
        in_valid1 = 4'b1111; out_ready1 = 1'b1; in_valid0 = 4'b1111; out_ready0 = 1'b1;
        #1;
        n_checks++; if (in_ready1 !== 4'b0000) begin n_fail++; $display("FAIL mid_rst_ready1: got %b want %b", in_ready1, 4'b0000); end
        n_checks++; if (in_ready0 !== 4'b0000) begin n_fail++; $display("FAIL mid_rst_ready0: got %b want %b", in_ready0, 4'b0000); end
        @(negedge clk);
        n_checks++; if (out_valid1 !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid1: got %b want 0", out_valid1); end
        n_checks++; if (out_data1 !== 32'h0) begin n_fail++; $display("FAIL mid_rst_data1: got %h want 0", out_data1); end
        n_checks++; if (out_chan1 !== 2'd0) begin n_fail++; $display("FAIL mid_rst_chan1: got %0d want 0", out_chan1); end
        n_checks++; if (dbg_rr1 !== 2'd0) begin n_fail++; $display("FAIL mid_rst_ptr: got %0d want 0", dbg_rr1); end
        n_checks++; if (out_valid0 !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid0: got %b want 0", out_valid0); end
        n_checks++; if (out_data0 !== 32'h0) begin n_fail++; $display("FAIL mid_rst_data0: got %h want 0", out_data0); end
        reset = 1'b0;
        in_valid0 = 4'b0000;
        in_data1 = {32'hC3, 32'hC2, 32'hC1, 32'hC0}; in_valid1 = 4'b1001;
        #1;
        n_checks++; if (in_ready1 !== 4'b0001) begin n_fail++; $display("FAIL mid_post_ready: got %b want %b", in_ready1, 4'b0001); end
        @(negedge clk);
        n_checks++; if (out_chan1 !== 2'd0) begin n_fail++; $display("FAIL mid_post_chan: got %0d want 0", out_chan1); end
        n_checks++; if (out_data1 !== 32'hC0) begin n_fail++; $display("FAIL mid_post_data: got %h want c0", out_data1); end
        in_valid1 = 4'b0000;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_select();
        test_sel_range();
`ifndef MUX_SKID_EN
        test_stall();
`else
        test_skid();
`endif
        test_round_robin();
        test_rr_skip();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
